uart_tx_fifo: RTL
=================

# uart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO. It serialises words of configurable width with optional parity and one or two stop bits. It sits between the matrix-result datapath and the board TX pin, and replaces the fixed 8N1 single-byte transmitter. The producer can push a whole burst of result bytes without polling `busy` per byte.

## Interface

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- BAUD_RATE, 9600: line rate in bit/s.
- BAUD_TICK, CLK_FREQ/BAUD_RATE: clocks per bit, integer-truncated. Legal range is 2..65535.
- DATA_BITS, 8: payload bits per frame. Legal values are 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 16: number of FIFO entries. Must be a power of two, at least 2.

Ports:
- clk, input, 1: system clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- data, input, DATA_BITS: word to transmit.
- wr_en, input, 1: write request. The word is accepted on an edge where wr_en=1 and full=0.
- full, output, 1: FIFO holds FIFO_DEPTH words.
- fifo_count, output, $clog2(FIFO_DEPTH+1): number of words currently queued. Excludes the word being sent.
- overflow, output, 1: one-cycle pulse when wr_en=1 while full=1. The word is dropped.
- tx, output, 1: serial line. Idle level is 1.
- busy, output, 1: high while a frame is on the line.

## Operation

- FIFO: circular buffer with a read pointer, a write pointer and a count.
  - A write occurs on wr_en && !full.
  - A pop occurs when the FSM loads a word.
  - Simultaneous write and pop: the count is unchanged and both pointers advance.
  - `full` is evaluated before any same-cycle pop. A write while full is always dropped and asserts `overflow`, even if a pop occurs that same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, busy=0. If fifo_count>0, pop the head word, drive tx=0, set busy=1, and enter START.
  - START: hold the bit for BAUD_TICK clocks, then go to DATA.
  - DATA: send DATA_BITS bits, LSB first, each held BAUD_TICK clocks. Then go to PARITY if PARITY≠0, otherwise STOP.
  - PARITY: odd mode sends ~^word; even mode sends ^word. Hold BAUD_TICK clocks.
  - STOP: tx=1 for STOP_BITS×BAUD_TICK clocks. On the final clock of STOP:
    - If fifo_count>0, pop the next word and go straight to START. No idle gap; busy stays 1.
    - Otherwise return to IDLE and drop busy.
- Counters:
  - 16-bit tick counter counts 0..BAUD_TICK-1 and wraps at each bit boundary.
  - Bit index is wide enough for DATA_BITS.
  - Both are cleared on every state entry.
- Parity is computed from the registered popped word, not from the live FIFO head.
- Reset (rst_n=0, asynchronous, any time including mid-frame):
  - tx=1, busy=0, full=0, fifo_count=0, overflow=0.
  - FSM goes to IDLE. Pointers and counters clear.
  - Queued words are discarded; a partial frame is abandoned.
  - After release, no frame starts until a new write.

## Timing

- Frame length is (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × BAUD_TICK clocks.
- Write into an empty FIFO at edge N with FSM in IDLE:
  - fifo_count=1 after edge N.
  - Pop at edge N+1: tx falls and busy rises at edge N+1, fifo_count returns to 0.
  - Latency is one clock.
- Every bit boundary falls exactly BAUD_TICK clocks after the previous one. There is no cumulative drift inside a frame.
- Back-to-back frames: the next start bit begins the clock after the last stop-bit clock.
- Outputs are registered; tx has no combinational path from inputs.
- overflow is high for exactly the cycle following the offending edge.

## Test plan

All scenarios use CLK_FREQ=1000000 and BAUD_RATE=100000, giving BAUD_TICK=10.

- **8N1 single word.** Write 0x55 once. Expect tx low at N+1 for 10 clocks, then bits 1,0,1,0,1,0,1,0 at 10 clocks each, then stop high for 10 clocks. busy is high for exactly 100 clocks.
- **Parity.** With PARITY=2, DATA_BITS=8, write 0x07; the parity bit must be 1 and the frame 110 clocks. With PARITY=1, the same word gives a parity bit of 0.
- **Two stop bits, 7 data bits.** With STOP_BITS=2, DATA_BITS=7, write 0x7F. Expect a 100-clock frame with tx high for the final 20 clocks.
- **FIFO fill and overflow.** With FIFO_DEPTH=4, write words 0x01..0x06 on 6 consecutive edges starting while idle. Expect:
  - 0x06 dropped, with a single-cycle overflow pulse.
  - full=1 after the fifth write.
  - Exactly 5 frames (0x01..0x05) sent back-to-back, with busy continuously high for 500 clocks.
- **Simultaneous write and pop.** With one word queued, write on the final STOP clock of the current frame. Expect fifo_count unchanged and both words transmitted in order.
- **Reset mid-frame.** With 3 words queued, pull rst_n low during DATA bit 3. Expect tx=1, busy=0 and fifo_count=0 immediately, without waiting for a clock edge. After release, tx stays 1 with no further frames until a new write.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Producer-side bus of uart_tx_fifo: write port, FIFO status and the serial line.
interface uart_tx_fifo_if #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 16
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_BITS-1:0] data;
  logic                 wr_en;
  logic                 full;
  logic [CNT_W-1:0]     fifo_count;
  logic                 overflow;
  logic                 tx;
  logic                 busy;

  modport master (
    output data, wr_en,
    input  full, fifo_count, overflow, tx, busy
  );

  modport slave (
    input  data, wr_en,
    output full, fifo_count, overflow, tx, busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular FIFO; frames are start, DATA_BITS LSB-first,
// optional parity and one or two stop bits, sent back-to-back while words are queued.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned BAUD_TICK  = CLK_FREQ / BAUD_RATE,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_fifo_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS);
  localparam int unsigned TICK_W = 16;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BAUD_TICK - 1);

  if (CLK_FREQ == 0 || BAUD_RATE == 0 || BAUD_TICK < 2 || BAUD_TICK > 65535 ||
      DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("uart_tx_fifo: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  state_e               state_q,    state_d;
  logic [DATA_BITS-1:0] word_q,     word_d;
  logic [TICK_W-1:0]    tick_q,     tick_d;
  logic [BIT_W-1:0]     bit_idx_q,  bit_idx_d;
  logic [PTR_W-1:0]     rd_ptr_q,   rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q,   wr_ptr_d;
  logic [CNT_W-1:0]     count_q,    count_d;
  logic                 full_q,     full_d;
  logic                 overflow_q, overflow_d;
  logic                 tx_q,       tx_d;
  logic                 busy_q,     busy_d;

  logic push_c;
  logic pop_c;
  logic bit_end_c;
  logic parity_bit_c;

  // Next-state logic for the FIFO bookkeeping and the frame sequencer.
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    bit_idx_d    = bit_idx_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    tx_d         = tx_q;
    busy_d       = busy_q;
    pop_c        = 1'b0;

    // full is the registered flag, so a same-cycle pop never rescues a write.
    push_c       = bus.wr_en && !full_q;
    overflow_d   = bus.wr_en && full_q;
    bit_end_c    = (tick_q == TICK_LAST);
    tick_d       = bit_end_c ? '0 : tick_q + TICK_W'(1);
    parity_bit_c = (PARITY == 1) ? ~^word_q : ^word_q;

    case (state_q)
      S_IDLE: begin
        tick_d    = '0;
        bit_idx_d = '0;
        if (count_q != '0) begin
          pop_c = 1'b1;
        end
      end
      S_START: begin
        if (bit_end_c) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
          tx_d      = word_q[0];
        end
      end
      S_DATA: begin
        if (bit_end_c) begin
          if (bit_idx_q == BIT_W'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = parity_bit_c;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
            tx_d      = word_q[bit_idx_d];
          end
        end
      end
      S_PARITY: begin
        if (bit_end_c) begin
          state_d   = S_STOP;
          bit_idx_d = '0;
          tx_d      = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end_c) begin
          if (bit_idx_q == BIT_W'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            if (count_q != '0) begin
              pop_c = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Loading a word always opens a fresh frame with the start bit.
    if (pop_c) begin
      word_d    = mem[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      state_d   = S_START;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      tick_d    = '0;
      bit_idx_d = '0;
    end

    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    full_d = (count_d == CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      tick_q     <= '0;
      bit_idx_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      tick_q     <= tick_d;
      bit_idx_q  <= bit_idx_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr_q] <= bus.data;
    end
  end

  assign bus.tx         = tx_q;
  assign bus.busy       = busy_q;
  assign bus.full       = full_q;
  assign bus.fifo_count = count_q;
  assign bus.overflow   = overflow_q;

endmodule
